// File: rtl/qos_classifier.sv
// qos_classifier: parses framed byte packets and steers each whole
// packet into the class FIFO named by its header byte.
`timescale 1ns/1ps
module qos_classifier #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [3:0]        Full,
  input  logic              pausa,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [3:0]        WRITE,
  output logic [3:0]        pkt_done,
  output logic              err_abort,
  input  logic [1:0]        stat_sel,
  output logic [CNT_W-1:0]  pkt_count
);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [5:0]     rem_q, rem_d;
  logic [1:0]     cls_q, cls_d;
  logic [7:0]     idle_q, idle_d;
  logic           abort_d;
  logic           inc;
  logic           xfer;
  logic [1:0]     wcls;
  logic [CNT_W-1:0] cnt_q [4];

  // In IDLE the target class comes from the header on the bus.
  assign wcls = (state_q == IDLE) ? DATA_IN[7:6] : cls_q;

  assign ready_out = !RESET && !pausa && !Full[wcls];
  assign xfer      = valid_in && ready_out;
  assign pkt_count = cnt_q[stat_sel];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cls_d   = cls_q;
    idle_d  = idle_q;
    abort_d = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_d = '0;
        if (xfer) begin
          cls_d = DATA_IN[7:6];
          rem_d = DATA_IN[5:0];
          if (DATA_IN[5:0] == 6'd0) begin
            inc = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          rem_d  = rem_q - 6'd1;
          idle_d = '0;
          if (rem_q == 6'd1) begin
            state_d = IDLE;
            inc     = 1'b1;
          end
        end else if (valid_in) begin
          idle_d = '0;
        end else if (idle_q == TO_LAST) begin
          state_d = IDLE;
          idle_d  = '0;
          abort_d = 1'b1;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      cls_q     <= '0;
      idle_q    <= '0;
      DATA_OUT  <= '0;
      WRITE     <= '0;
      pkt_done  <= '0;
      err_abort <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cls_q     <= cls_d;
      idle_q    <= idle_d;
      err_abort <= abort_d;
      if (xfer) begin
        DATA_OUT <= DATA_IN;
      end
      WRITE    <= xfer ? (4'b0001 << wcls) : 4'b0000;
      pkt_done <= inc ? (4'b0001 << wcls) : 4'b0000;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (inc) begin
      cnt_q[wcls] <= cnt_q[wcls] + 1'b1;
    end
  end

endmodule

// File: tb/tb_qos_classifier.sv
// tb_qos_classifier: random and directed stimulus, packet-level
// reference model, write/abort scoreboard checked by a monitor.
`timescale 1ns/1ps
module tb_qos_classifier;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  DATA_IN = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [3:0]  Full = '0;
  logic        pausa = 1'b0;
  logic [7:0]  DATA_OUT;
  logic [3:0]  WRITE;
  logic [3:0]  pkt_done;
  logic        err_abort;
  logic [1:0]  stat_sel = '0;
  logic [15:0] pkt_count;

  always #5 CLK = ~CLK;

  qos_classifier #(
    .DATA_W(8), .TIMEOUT(TO), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .DATA_IN(DATA_IN), .valid_in(valid_in),
    .ready_out(ready_out), .Full(Full),
    .pausa(pausa), .DATA_OUT(DATA_OUT),
    .WRITE(WRITE), .pkt_done(pkt_done),
    .err_abort(err_abort), .stat_sel(stat_sel),
    .pkt_count(pkt_count)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] w;
    logic [3:0] done;
  } exp_t;

  exp_t wq[$];
  int   aq[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Packet-level model: are we inside a packet, which class,
  // how many payload bytes remain, how long the source has idled.
  bit   in_pkt = 0;
  int   m_cls = 0;
  int   m_rem = 0;
  int   m_idle = 0;
  int   cnt[4] = '{0, 0, 0, 0};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] oh(int c);
    return 4'b0001 << c;
  endfunction

  task automatic model_reset();
    in_pkt = 0;
    m_cls  = 0;
    m_rem  = 0;
    m_idle = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    wq.delete();
    aq.delete();
  endtask

  task automatic step(bit v, logic [7:0] d, logic [3:0] f, bit p);
    int   c;
    bit   r;
    exp_t ne;
    @(negedge CLK);
    valid_in = v;
    DATA_IN  = d;
    Full     = f;
    pausa    = p;
    #1;
    c = in_pkt ? m_cls : int'(d[7:6]);
    r = !p && !f[c];
    if (v || in_pkt) chk("ready_out", 32'(ready_out), 32'(r));
    if (v && r) begin
      ne.d = d;
      ne.w = oh(c);
      ne.done = 4'b0000;
      if (!in_pkt) begin
        if (d[5:0] == 6'd0) begin
          ne.done = oh(c);
          cnt[c]++;
        end else begin
          in_pkt = 1;
          m_cls  = c;
          m_rem  = int'(d[5:0]);
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          ne.done = oh(c);
          cnt[c]++;
          in_pkt = 0;
        end
      end
      wq.push_back(ne);
      m_idle = 0;
    end else if (in_pkt) begin
      if (v) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          in_pkt = 0;
          m_idle = 0;
          aq.push_back(cyc + 1);
        end
      end
    end
  endtask

  task automatic check_counts();
    @(posedge CLK);
    #2;
    for (int i = 0; i < 4; i++) begin
      stat_sel = 2'(i);
      #0.5;
      chk($sformatf("pkt_count[%0d]", i), 32'(pkt_count),
          32'(cnt[i] & 16'hffff));
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_write", 32'(WRITE), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    chk("rst_abort", 32'(err_abort), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    model_reset();
    valid_in = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b0;
  endtask

  always @(posedge CLK) begin
    cyc++;
    #1;
    if (!RESET) begin
      if (WRITE != 4'b0000) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'(WRITE), 32'd0);
        end else begin
          e = wq.pop_front();
          chk("data_out", 32'(DATA_OUT), 32'(e.d));
          chk("write", 32'(WRITE), 32'(e.w));
          chk("pkt_done", 32'(pkt_done), 32'(e.done));
        end
      end else begin
        chk("done_no_write", 32'(pkt_done), 32'd0);
        chk("write_due", 32'(wq.size()), 32'd0);
        wq.delete();
      end
      if (err_abort) begin
        if (aq.size() == 0) chk("unexpected_abort", 32'd1, 32'd0);
        else chk("abort_cycle", 32'(cyc), 32'(aq.pop_front()));
      end
    end
  end

  initial begin
    #3;
    chk("init_write", 32'(WRITE), 32'd0);
    chk("init_done", 32'(pkt_done), 32'd0);
    chk("init_abort", 32'(err_abort), 32'd0);
    chk("init_ready", 32'(ready_out), 32'd0);
    chk("init_data", 32'(DATA_OUT), 32'd0);
    chk("init_count", 32'(pkt_count), 32'd0);
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b0;

    step(1, 8'h82, 4'h0, 0);
    step(1, 8'h11, 4'h0, 0);
    step(1, 8'h22, 4'h0, 0);
    step(0, 8'h00, 4'h0, 0);
    check_counts();

    step(1, 8'h00, 4'h0, 0);
    step(1, 8'hC0, 4'h0, 0);
    step(0, 8'h00, 4'h0, 0);
    check_counts();

    step(1, 8'h43, 4'h0, 0);
    step(1, 8'hA1, 4'h0, 0);
    repeat (5) step(1, 8'hB2, 4'b0010, 0);
    step(1, 8'hB2, 4'h0, 0);
    step(1, 8'hC3, 4'h0, 0);
    step(0, 8'h00, 4'h0, 0);
    check_counts();

    step(1, 8'h05, 4'h0, 0);
    step(1, 8'hAA, 4'h0, 0);
    repeat (6) step(0, 8'h00, 4'h0, 0);
    step(1, 8'h40, 4'h0, 0);
    step(0, 8'h00, 4'h0, 0);
    check_counts();

    step(1, 8'h85, 4'h0, 0);
    step(1, 8'h01, 4'h0, 0);
    do_reset();
    step(1, 8'hC1, 4'h0, 0);
    step(1, 8'h5A, 4'h0, 0);
    step(0, 8'h00, 4'h0, 0);
    check_counts();

    step(1, 8'h42, 4'h0, 0);
    repeat (3) step(1, 8'h77, 4'h0, 1);
    step(1, 8'h77, 4'h0, 0);
    step(1, 8'h78, 4'h0, 1);
    step(1, 8'h78, 4'h0, 0);
    repeat (2) step(1, 8'hC0, 4'h0, 1);
    step(1, 8'hC0, 4'h0, 0);
    step(0, 8'h00, 4'h0, 0);
    check_counts();

    repeat (3000) begin
      step($urandom_range(9) < 7, 8'($urandom),
           ($urandom_range(7) == 0) ? 4'($urandom) : 4'd0,
           $urandom_range(9) == 0);
    end
    repeat (TO + 2) step(0, 8'h00, 4'h0, 0);
    check_counts();

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("aq_empty", 32'(aq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qos_classifier.md
Name: qos_classifier

Overview:
- Ingress stage directly upstream of the four class FIFOs in the QoS block; it produces their DATA_IN/WRITE inputs.
- Parses a byte stream of framed packets and steers each whole packet (header plus payload) into the class FIFO named in its header.
- Applies per-class backpressure from FIFO full flags and the global pause from the control FSM.
- Keeps per-class packet counters and aborts packets whose source stalls too long mid-packet.

Parameters:
- DATA_W, 8, stream word width; header format is defined for 8.
- TIMEOUT, 16, consecutive mid-packet idle cycles (valid_in low) before abort; legal range 1..255.
- CNT_W, 16, width of each per-class packet counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DATA_IN  in  DATA_W  stream byte from the source.
- valid_in  in  1  DATA_IN holds a byte.
- ready_out  out  1  stage accepts a byte this cycle; transfer = valid_in & ready_out.
- Full  in  4  per-class FIFO full flags; bit i is class i.
- pausa  in  1  global pause from the control FSM.
- DATA_OUT  out  DATA_W  registered byte to the class FIFOs (shared bus).
- WRITE  out  4  registered one-hot push strobe; bit i pushes FIFO i.
- pkt_done  out  4  one-cycle pulse, coincident with the last byte's WRITE, one bit per class.
- err_abort  out  1  one-cycle pulse when a packet is aborted by timeout.
- stat_sel  in  2  selects which class counter drives pkt_count.
- pkt_count  out  CNT_W  completed-packet count of class stat_sel (combinational mux of registers).

Behaviour:
- Header byte format:
  - bits[7:6] = class c.
  - bits[5:0] = payload length L (0..63).
  - The header is itself written to FIFO c, so a packet is L+1 bytes.
- Reset (async, any time, including mid-packet):
  - state=IDLE, DATA_OUT=0, WRITE=0, pkt_done=0, err_abort=0, all counters=0, idle counter=0.
  - ready_out=0 while RESET is high.
- States:
  - IDLE (expect header).
  - PAYLOAD (rem bytes outstanding, class latched in cls_q).
- ready_out is combinational and is forced 0 whenever pausa=1:
  - IDLE: !Full[DATA_IN[7:6]]; meaningful only when valid_in=1.
  - PAYLOAD: !Full[cls_q].
- Latency: an accepted byte appears on DATA_OUT with WRITE[c]=1 on the next cycle. No transfer means WRITE=0 next cycle; DATA_OUT holds its last value.
- IDLE, on transfer:
  - Latch cls_q=c and rem=L.
  - L=0: stay IDLE, pulse pkt_done[c] with that write, increment counter c.
  - L>0: go to PAYLOAD.
- PAYLOAD, on transfer:
  - Decrement rem.
  - If rem was 1: go to IDLE, pulse pkt_done[cls_q], increment counter cls_q.
- Back-to-back: a new header is accepted the cycle after the last payload byte with no bubble.
- Idle counter (PAYLOAD only):
  - Increments each cycle with valid_in=0.
  - Clears on any cycle with valid_in=1.
  - Stalls caused by Full or pausa (valid_in=1, ready_out=0) do not count.
- Timeout: when the idle counter reaches TIMEOUT:
  - Go to IDLE, pulse err_abort next cycle, and do not increment the counter.
  - Bytes already pushed remain in the FIFO.
- Counters wrap modulo 2^CNT_W with no saturation.
- Never more than one WRITE bit high per cycle.
- Full and pausa changing mid-packet only gate ready_out; state is preserved.

Test Plan:
- Reset, then header 8'h82 (class 2, L=2) followed by 8'h11, 8'h22, all valid → WRITE=4'b0100 on 3 consecutive cycles carrying 82,11,22; pkt_done[2] high with the 22 byte; stat_sel=2 gives pkt_count=1.
- Headers 8'h00 then 8'hC0 (L=0, classes 0 and 3) back-to-back → WRITE=0001 then 1000 on consecutive cycles; pkt_done pulses each cycle; counters 0 and 3 each equal 1.
- Packet 8'h43 (class 1, L=3) with Full[1] raised after the first payload byte for 5 cycles → ready_out=0 for those 5 cycles; no WRITE; no abort even when TIMEOUT=4; the remaining 2 bytes follow after Full[1] drops.
- TIMEOUT=4, header 8'h05 and one payload byte, then valid_in=0 → err_abort pulses once about 4 cycles later; state is IDLE; next byte 8'h40 is treated as a header (WRITE[1]); counter 0 stays 0.
- RESET asserted asynchronously mid-PAYLOAD → WRITE, pkt_done, and pkt_count go to 0 immediately; after release, first byte is parsed as a header.
- pausa=1 with valid_in=1 → ready_out=0 and no WRITE; after pausa drops, transfer resumes with correct bytes and ordering.
